// File: rtl/psum_accumulator_if.sv
// rtl/psum_accumulator_if.sv - psum input beat and requantised output stream link
interface psum_accumulator_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 7
);
  localparam int COL_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;

  logic                                 in_valid;
  logic                                 in_ready;
  logic [NUM_COL-1:0][2*DATA_WIDTH-1:0] in_psum;
  logic                                 out_valid;
  logic                                 out_ready;
  logic signed [DATA_WIDTH-1:0]         out_data;
  logic [COL_W-1:0]                     out_col;
  logic                                 out_last;

  // Producer of psum beats and consumer of results (PE array / output buffer side)
  modport master (
    output in_valid, in_psum, out_ready,
    input  in_ready, out_valid, out_data, out_col, out_last
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_psum, out_ready,
    output in_ready, out_valid, out_data, out_col, out_last
  );
endinterface

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - multi-pass column psum accumulator with requantised drain
module psum_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 7,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          cfg_num_pass,
  input  logic [4:0]          cfg_shift,
  psum_accumulator_if.slave   bus,
  output logic                busy,
  output logic                overflow
);
  localparam int COL_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] DW_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] DW_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q   [NUM_COL];
  logic signed [ACC_WIDTH-1:0]  acc_add [NUM_COL];
  logic signed [ACC_WIDTH:0]    sum_w   [NUM_COL];
  logic [NUM_COL-1:0]           acc_sat;
  logic [7:0]                   npass_q, pass_cnt_q, npass_cfg;
  logic [4:0]                   shift_q;
  logic [COL_W-1:0]             col_q;
  logic                         in_ready_w, out_valid_w, accept, emit;
  logic signed [ACC_WIDTH-1:0]  acc_sel, shifted;

  // A pass count of zero would never drain, so it behaves as a single pass
  assign npass_cfg   = (cfg_num_pass == 8'd0) ? 8'd1 : cfg_num_pass;
  assign in_ready_w  = (state_q != DRAIN);
  assign out_valid_w = (state_q == DRAIN);
  assign accept      = bus.in_valid && in_ready_w;
  assign emit        = out_valid_w && bus.out_ready;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_col   = col_q;
  assign bus.out_last  = out_valid_w && (col_q == LAST_COL);
  assign busy          = (state_q != IDLE);

  // Per-column add with one guard bit; clamp to the accumulator range on signed overflow
  always_comb begin
    for (int c = 0; c < NUM_COL; c++) begin
      sum_w[c]   = (ACC_WIDTH+1)'(acc_q[c]) + (ACC_WIDTH+1)'(signed'(bus.in_psum[c]));
      acc_sat[c] = (sum_w[c][ACC_WIDTH] != sum_w[c][ACC_WIDTH-1]);
      acc_add[c] = acc_sat[c] ? (sum_w[c][ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                              : sum_w[c][ACC_WIDTH-1:0];
    end
  end

  // Requantise the column being drained: floor shift, then clamp to the output word
  always_comb begin
    acc_sel      = acc_q[col_q];
    shifted      = acc_sel >>> shift_q;
    bus.out_data = '0;
    if (out_valid_w) begin
      if (shifted > DW_MAX)      bus.out_data = DW_MAX[DATA_WIDTH-1:0];
      else if (shifted < DW_MIN) bus.out_data = DW_MIN[DATA_WIDTH-1:0];
      else                       bus.out_data = shifted[DATA_WIDTH-1:0];
    end
  end

  // Next-state: collect npass beats, then drain every column once
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (npass_cfg <= 8'd1) ? DRAIN : ACCUM;
      ACCUM:   if (accept && ({1'b0, pass_cnt_q} + 9'd1 == {1'b0, npass_q})) state_d = DRAIN;
      DRAIN:   if (emit && (col_q == LAST_COL)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Accumulators, tile config capture, pass/column counters and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_COL; c++) acc_q[c] <= '0;
      npass_q    <= 8'd0;
      pass_cnt_q <= 8'd0;
      shift_q    <= 5'd0;
      col_q      <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          for (int c = 0; c < NUM_COL; c++) acc_q[c] <= ACC_WIDTH'(signed'(bus.in_psum[c]));
          npass_q    <= npass_cfg;
          shift_q    <= cfg_shift;
          pass_cnt_q <= 8'd1;
          overflow   <= 1'b0;
        end
        ACCUM: if (accept) begin
          for (int c = 0; c < NUM_COL; c++) acc_q[c] <= acc_add[c];
          pass_cnt_q <= pass_cnt_q + 8'd1;
          overflow   <= overflow | (|acc_sat);
        end
        DRAIN: if (emit) begin
          col_q <= (col_q == LAST_COL) ? '0 : col_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - directed self-checking bench for psum_accumulator
module tb_psum_accumulator;
  localparam int DW = 16;
  localparam int NC = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_num_pass;
  logic [4:0] cfg_shift;
  logic       busy, overflow;
  int         tests_run = 0;
  int         tests_failed = 0;

  logic signed [DW-1:0] got_data [NC];
  logic [2:0]           got_col  [NC];
  logic                 got_last [NC];

  psum_accumulator_if #(.DATA_WIDTH(DW), .NUM_COL(NC)) bus ();

  psum_accumulator #(.DATA_WIDTH(DW), .NUM_COL(NC), .ACC_WIDTH(40)) dut (
    .clk(clk), .rst(rst), .cfg_num_pass(cfg_num_pass), .cfg_shift(cfg_shift),
    .bus(bus), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_all(input logic signed [31:0] v);
    for (int c = 0; c < NC; c++) bus.in_psum[c] = v;
  endtask

  task automatic send_beat();
    bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain_all(output int n);
    n = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && n < NC; cyc++) begin
      if (bus.out_valid) begin
        got_data[n] = bus.out_data; got_col[n] = bus.out_col; got_last[n] = bus.out_last;
        n++;
      end
      @(posedge clk); @(negedge clk);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; set_all(0);
    cfg_num_pass = 8'd1; cfg_shift = 5'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 ||
        bus.out_col !== 3'd0 || bus.out_last !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%0d out_col=%0d out_last=%b busy=%b ovf=%b, required 1 0 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_col, bus.out_last, busy, overflow);
    end
  endtask

  task automatic test_single_pass();
    int n;
    cfg_num_pass = 8'd1; cfg_shift = 5'd0;
    for (int c = 0; c < NC; c++) bus.in_psum[c] = 32'(c + 1);
    send_beat();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL t1_latency: out_valid=%b in_ready=%b busy=%b, required 1 0 1", bus.out_valid, bus.in_ready, busy);
    end
    drain_all(n);
    tests_run++;
    if (n !== NC) begin tests_failed++; $display("FAIL t1_count: got %0d beats, required %0d", n, NC); end
    for (int c = 0; c < n; c++) begin
      tests_run++;
      if (got_data[c] !== 16'(c + 1) || got_col[c] !== 3'(c) || got_last[c] !== (c == NC - 1)) begin
        tests_failed++;
        $display("FAIL t1_col%0d: data=%0d col=%0d last=%b, required %0d %0d %b",
                 c, got_data[c], got_col[c], got_last[c], c + 1, c, (c == NC - 1));
      end
    end
    tests_run++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL t1_idle: busy=%b in_ready=%b out_valid=%b, required 0 1 0", busy, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_multi_pass();
    int n;
    cfg_num_pass = 8'd4; cfg_shift = 5'd2; set_all(100);
    send_beat();
    cfg_num_pass = 8'd1; cfg_shift = 5'd0;
    send_beat(); send_beat();
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL t2_after3: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
    send_beat();
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL t2_after4: in_ready=%b out_valid=%b, required 0 1", bus.in_ready, bus.out_valid);
    end
    bus.in_valid = 1'b1; set_all(9999);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    bus.in_valid = 1'b0;
    drain_all(n);
    tests_run++;
    if (n !== NC) begin tests_failed++; $display("FAIL t2_count: got %0d beats, required %0d", n, NC); end
    for (int c = 0; c < n; c++) begin
      tests_run++;
      if (got_data[c] !== 16'sd100 || got_col[c] !== 3'(c)) begin
        tests_failed++;
        $display("FAIL t2_col%0d: data=%0d col=%0d, required 100 %0d", c, got_data[c], got_col[c], c);
      end
    end
  endtask

  task automatic test_negative();
    int n;
    cfg_num_pass = 8'd2; cfg_shift = 5'd1;
    set_all(-5); send_beat();
    set_all(-4); send_beat();
    drain_all(n);
    tests_run++;
    if (n !== NC) begin tests_failed++; $display("FAIL t3_count: got %0d beats, required %0d", n, NC); end
    for (int c = 0; c < n; c++) begin
      tests_run++;
      if (got_data[c] !== -16'sd5) begin
        tests_failed++;
        $display("FAIL t3_col%0d: data=%0d, required -5", c, got_data[c]);
      end
    end
  endtask

  task automatic test_no_overflow();
    int n;
    cfg_num_pass = 8'd2; cfg_shift = 5'd0;
    set_all(32'h7FFF_FFFF); send_beat(); send_beat();
    drain_all(n);
    tests_run++;
    if (n !== NC) begin tests_failed++; $display("FAIL t4_count: got %0d beats, required %0d", n, NC); end
    for (int c = 0; c < n; c++) begin
      tests_run++;
      if (got_data[c] !== 16'sd32767) begin
        tests_failed++;
        $display("FAIL t4_col%0d: data=%0d, required 32767", c, got_data[c]);
      end
    end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL t4_overflow: overflow=%b, required 0", overflow); end
  endtask

  task automatic test_dw_clamp();
    int n;
    logic signed [31:0] vin [NC];
    logic signed [15:0] vexp [NC];
    vin  = '{100000, -100000, 32767, -32768, 32768, -32769, 0};
    vexp = '{32767, -32768, 32767, -32768, 32767, -32768, 0};
    cfg_num_pass = 8'd0; cfg_shift = 5'd0;
    for (int c = 0; c < NC; c++) bus.in_psum[c] = vin[c];
    send_beat();
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL npass0_as_1: out_valid=%b, required 1", bus.out_valid);
    end
    drain_all(n);
    tests_run++;
    if (n !== NC) begin tests_failed++; $display("FAIL clamp_count: got %0d beats, required %0d", n, NC); end
    for (int c = 0; c < n; c++) begin
      tests_run++;
      if (got_data[c] !== vexp[c]) begin
        tests_failed++;
        $display("FAIL clamp_col%0d: data=%0d, required %0d", c, got_data[c], vexp[c]);
      end
    end
  endtask

  task automatic test_stall();
    int n = 0;
    bit stalled = 1'b0;
    logic signed [15:0] hold_data;
    logic [2:0] hold_col;
    cfg_num_pass = 8'd3; cfg_shift = 5'd0;
    for (int c = 0; c < NC; c++) bus.in_psum[c] = 32'(c * 10);
    send_beat();
    for (int c = 0; c < NC; c++) bus.in_psum[c] = 32'(c * 10 + 1);
    send_beat();
    for (int c = 0; c < NC; c++) bus.in_psum[c] = 32'(-c);
    send_beat();
    for (int cyc = 0; cyc < 300 && n < NC; cyc++) begin
      bus.out_ready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (bus.out_valid) begin
        if (stalled) begin
          tests_run++;
          if (bus.out_data !== hold_data || bus.out_col !== hold_col) begin
            tests_failed++;
            $display("FAIL t5_stable: data=%0d col=%0d, required %0d %0d", bus.out_data, bus.out_col, hold_data, hold_col);
          end
        end
        if (bus.out_ready) begin
          tests_run++;
          if (bus.out_col !== 3'(n) || bus.out_data !== 16'(19 * n + 1)) begin
            tests_failed++;
            $display("FAIL t5_beat%0d: data=%0d col=%0d, required %0d %0d", n, bus.out_data, bus.out_col, 19 * n + 1, n);
          end
          n++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; hold_data = bus.out_data; hold_col = bus.out_col;
        end
      end
      @(posedge clk); @(negedge clk);
    end
    bus.out_ready = 1'b0;
    tests_run++;
    if (n !== NC || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL t5_done: beats=%0d busy=%b, required %0d 0", n, busy, NC);
    end
  endtask

  task automatic test_reset_mid_tile();
    int n;
    cfg_num_pass = 8'd4; cfg_shift = 5'd0; set_all(14);
    send_beat(); send_beat();
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL t6_busy: busy=%b, required 1", busy); end
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 ||
        bus.out_col !== 3'd0 || bus.out_last !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL t6_reset: busy=%b in_ready=%b out_valid=%b data=%0d col=%0d last=%b ovf=%b, required 0 1 0 0 0 0 0",
               busy, bus.in_ready, bus.out_valid, bus.out_data, bus.out_col, bus.out_last, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    cfg_num_pass = 8'd1;
    for (int c = 0; c < NC; c++) bus.in_psum[c] = 32'(3 * c - 10);
    send_beat();
    drain_all(n);
    tests_run++;
    if (n !== NC) begin tests_failed++; $display("FAIL t6_count: got %0d beats, required %0d", n, NC); end
    for (int c = 0; c < n; c++) begin
      tests_run++;
      if (got_data[c] !== 16'(3 * c - 10)) begin
        tests_failed++;
        $display("FAIL t6_col%0d: data=%0d, required %0d", c, got_data[c], 3 * c - 10);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    cfg_num_pass = 8'd1; cfg_shift = 5'd0;
    for (int c = 0; c < NC; c++) bus.in_psum[c] = 32'(c);
    send_beat();
    for (int c = 0; c < NC; c++) bus.in_psum[c] = 32'(50 + c);
    bus.in_valid = 1'b1;
    drain_all(n);
    tests_run++;
    if (n !== NC) begin tests_failed++; $display("FAIL b2b_a_count: got %0d beats, required %0d", n, NC); end
    for (int c = 0; c < n; c++) begin
      tests_run++;
      if (got_data[c] !== 16'(c)) begin
        tests_failed++;
        $display("FAIL b2b_a_col%0d: data=%0d, required %0d", c, got_data[c], c);
      end
    end
    tests_run++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: in_ready=%b busy=%b, required 1 0", bus.in_ready, busy);
    end
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept: out_valid=%b, required 1", bus.out_valid);
    end
    drain_all(n);
    tests_run++;
    if (n !== NC) begin tests_failed++; $display("FAIL b2b_b_count: got %0d beats, required %0d", n, NC); end
    for (int c = 0; c < n; c++) begin
      tests_run++;
      if (got_data[c] !== 16'(50 + c)) begin
        tests_failed++;
        $display("FAIL b2b_b_col%0d: data=%0d, required %0d", c, got_data[c], 50 + c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_negative();
    test_no_overflow();
    test_dw_clamp();
    test_stall();
    test_reset_mid_tile();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
